// File: rtl/qam_pkg.sv
// -----------------------------------------------------------------------------
// qam_pkg
// Shared definitions for the QAM symbol mapper:
//   mode_t     - modulation mode encodings (BPSK / QPSK / 16-QAM / reserved)
//   state_t    - mapper controller states (IDLE, EMIT)
//   BPS_*      - bits carried by one symbol in each mode
//   SPB_*      - symbols produced from one input byte in each mode
//   helpers    - mode normalisation, bits-per-symbol and last symbol index
// No ports (package).
// -----------------------------------------------------------------------------
package qam_pkg;

   typedef enum logic [1:0] {
      MODE_BPSK  = 2'd0,
      MODE_QPSK  = 2'd1,
      MODE_QAM16 = 2'd2,
      MODE_RSVD  = 2'd3
   } mode_t;

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_t;

   localparam int BPS_BPSK  = 1;
   localparam int BPS_QPSK  = 2;
   localparam int BPS_QAM16 = 4;

   localparam int SPB_BPSK  = 8 / BPS_BPSK;
   localparam int SPB_QPSK  = 8 / BPS_QPSK;
   localparam int SPB_QAM16 = 8 / BPS_QAM16;

   // The reserved encoding behaves exactly like 16-QAM, so it is folded
   // away as soon as the mode is captured and never reaches the datapath.
   function automatic mode_t norm_mode(input logic [1:0] m);
      return (m == 2'd3) ? MODE_QAM16 : mode_t'(m);
   endfunction

   function automatic logic [2:0] bits_per_sym(input mode_t m);
      case (m)
         MODE_BPSK: return 3'(BPS_BPSK);
         MODE_QPSK: return 3'(BPS_QPSK);
         default:   return 3'(BPS_QAM16);
      endcase
   endfunction

   // Index of the final symbol of a byte, used to detect the byte boundary.
   function automatic logic [2:0] last_index(input mode_t m);
      case (m)
         MODE_BPSK: return 3'(SPB_BPSK - 1);
         MODE_QPSK: return 3'(SPB_QPSK - 1);
         default:   return 3'(SPB_QAM16 - 1);
      endcase
   endfunction

endpackage

// File: rtl/qam_mapper_axis_if.sv
// -----------------------------------------------------------------------------
// qam_mapper_axis_if
// Minimal AXI-Stream bundle used on both sides of the mapper.
//   DATA_W  - width of tdata
//   tdata   - payload
//   tvalid  - source has data
//   tready  - sink can accept
//   tlast   - frame end marker
// Modports: master (drives tdata/tvalid/tlast), slave (drives tready).
// -----------------------------------------------------------------------------
interface qam_mapper_axis_if #(
   parameter int DATA_W = 8
);

   logic [DATA_W-1:0] tdata;
   logic              tvalid;
   logic              tready;
   logic              tlast;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/qam_level_lut.sv
// -----------------------------------------------------------------------------
// qam_level_lut
// Combinational constellation lookup: turns the bits of one symbol into its
// signed I and Q amplitudes for the selected modulation.
//   mode   in  mode_t          - BPSK / QPSK / 16-QAM (reserved already folded)
//   sym    in  4               - symbol bits, right-aligned (unused MSBs ignored)
//   i_lvl  out signed IQ_W     - in-phase amplitude
//   q_lvl  out signed IQ_W     - quadrature amplitude
// -----------------------------------------------------------------------------
module qam_level_lut
   import qam_pkg::*;
#(
   parameter int IQ_W        = 16,
   parameter int SCALE_16QAM = 4914,
   parameter int SCALE_QPSK  = 10988,
   parameter int SCALE_BPSK  = 15539
) (
   input  mode_t                  mode,
   input  logic [3:0]             sym,
   output logic signed [IQ_W-1:0] i_lvl,
   output logic signed [IQ_W-1:0] q_lvl
);

   localparam logic signed [IQ_W-1:0] LVL_1 = IQ_W'(SCALE_16QAM);
   localparam logic signed [IQ_W-1:0] LVL_3 = IQ_W'(3 * SCALE_16QAM);
   localparam logic signed [IQ_W-1:0] LVL_Q = IQ_W'(SCALE_QPSK);
   localparam logic signed [IQ_W-1:0] LVL_B = IQ_W'(SCALE_BPSK);

   // Two-bit 16-QAM axis code: the low bit picks magnitude 1 or 3,
   // the high bit picks the sign.
   function automatic logic signed [IQ_W-1:0] qam16_level(input logic [1:0] b);
      case (b)
         2'd0:    return LVL_1;
         2'd1:    return LVL_3;
         2'd2:    return -LVL_1;
         default: return -LVL_3;
      endcase
   endfunction

   // A set bit always maps to the negative level; BPSK has no quadrature part.
   always_comb begin
      i_lvl = '0;
      q_lvl = '0;
      case (mode)
         MODE_BPSK: begin
            i_lvl = sym[0] ? -LVL_B : LVL_B;
         end
         MODE_QPSK: begin
            q_lvl = sym[0] ? -LVL_Q : LVL_Q;
            i_lvl = sym[1] ? -LVL_Q : LVL_Q;
         end
         default: begin
            q_lvl = qam16_level(sym[1:0]);
            i_lvl = qam16_level(sym[3:2]);
         end
      endcase
   end

endmodule

// File: rtl/qam_mapper_axis.sv
// -----------------------------------------------------------------------------
// qam_mapper_axis
// Byte-to-symbol mapper with AXI-Stream in and out. Each accepted byte is
// split LSB-first into 8 BPSK, 4 QPSK or 2 16-QAM symbols, one per output
// handshake. The mode is captured together with each byte.
//   aclk     in  1         - clock, rising edge
//   areset   in  1         - asynchronous active-high reset
//   mode     in  2         - 0 BPSK, 1 QPSK, 2 16-QAM, 3 treated as 16-QAM
//   s_axis   slave  (8)    - input bytes, tlast marks frame end
//   m_axis   master        - symbols: {conj_Q, conj_I, mod_Q, mod_I} (4*IQ_W)
//                            or {mod_Q, mod_I} (2*IQ_W) without conjugate
// Build option: define QAM_MAPPER_CONJ_EN to add the conjugate fields.
// -----------------------------------------------------------------------------
module qam_mapper_axis
   import qam_pkg::*;
#(
   parameter int IQ_W        = 16,
   parameter int SCALE_16QAM = 4914,
   parameter int SCALE_QPSK  = 10988,
   parameter int SCALE_BPSK  = 15539
) (
   input  logic               aclk,
   input  logic               areset,
   input  logic [1:0]         mode,
   qam_mapper_axis_if.slave   s_axis,
   qam_mapper_axis_if.master  m_axis
);

`ifdef QAM_MAPPER_CONJ_EN
   localparam int TDATA_W = 4 * IQ_W;
`else
   localparam int TDATA_W = 2 * IQ_W;
`endif

   // Every level must be representable as a signed IQ_W value, otherwise
   // the constellation would silently wrap.
   localparam longint LVL_MAX = (longint'(1) <<< (IQ_W - 1)) - 1;

   if ((longint'(3) * SCALE_16QAM > LVL_MAX) ||
       (longint'(SCALE_QPSK) > LVL_MAX) ||
       (longint'(SCALE_BPSK) > LVL_MAX)) begin : g_scale_check
      $error("qam_mapper_axis: a constellation level does not fit in signed IQ_W");
   end

   state_t               state;
   logic [7:0]           byte_q;
   mode_t                mode_q;
   logic                 last_q;
   logic [2:0]           k;
   logic [TDATA_W-1:0]   tdata_q;
   logic                 tvalid_q;
   logic                 tlast_q;

   logic                 last_sym;
   logic                 s_ready;
   logic                 accept;
   logic                 m_hs;

   mode_t                src_mode;
   logic [7:0]           src_byte;
   logic [2:0]           src_k;
   logic                 src_last;
   logic [5:0]           shift;
   logic [3:0]           sym_bits;
   logic                 next_last;
   logic [TDATA_W-1:0]   next_tdata;
   logic signed [IQ_W-1:0] i_lvl;
   logic signed [IQ_W-1:0] q_lvl;

   // A new byte is taken either when nothing is held, or in the same cycle
   // the final symbol of the held byte is handed off, so consecutive bytes
   // stream without a bubble.
   assign last_sym = (k == last_index(mode_q));
   assign s_ready  = (state == IDLE) || (last_sym && m_axis.tready);
   assign accept   = s_axis.tvalid && s_ready;
   assign m_hs     = tvalid_q && m_axis.tready;

   // The output register is always loaded with the symbol that will be shown
   // next: symbol 0 of an incoming byte, or symbol k+1 of the held byte.
   // Selecting the source before the lookup lets one LUT serve both cases.
   always_comb begin
      src_byte  = accept ? s_axis.tdata : byte_q;
      src_mode  = accept ? norm_mode(mode) : mode_q;
      src_k     = accept ? 3'd0 : k + 3'd1;
      src_last  = accept ? s_axis.tlast : last_q;
      shift     = 6'(src_k) * 6'(bits_per_sym(src_mode));
      sym_bits  = 4'(src_byte >> shift);
      next_last = src_last && (src_k == last_index(src_mode));
   end

   qam_level_lut #(
      .IQ_W        (IQ_W),
      .SCALE_16QAM (SCALE_16QAM),
      .SCALE_QPSK  (SCALE_QPSK),
      .SCALE_BPSK  (SCALE_BPSK)
   ) u_lut (
      .mode  (src_mode),
      .sym   (sym_bits),
      .i_lvl (i_lvl),
      .q_lvl (q_lvl)
   );

   // The conjugate keeps I and negates Q; a zero Q stays zero.
`ifdef QAM_MAPPER_CONJ_EN
   assign next_tdata = {-q_lvl, i_lvl, q_lvl, i_lvl};
`else
   assign next_tdata = {q_lvl, i_lvl};
`endif

   // Controller: accepting a byte always (re)starts emission at symbol 0;
   // otherwise each output handshake steps to the next symbol, and the
   // final handshake with no replacement byte drops back to IDLE.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state    <= IDLE;
         k        <= 3'd0;
         byte_q   <= 8'd0;
         mode_q   <= MODE_BPSK;
         last_q   <= 1'b0;
         tdata_q  <= '0;
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
      end else if (accept) begin
         state    <= EMIT;
         k        <= 3'd0;
         byte_q   <= s_axis.tdata;
         mode_q   <= src_mode;
         last_q   <= s_axis.tlast;
         tdata_q  <= next_tdata;
         tvalid_q <= 1'b1;
         tlast_q  <= next_last;
      end else begin
         case (state)
            EMIT: begin
               if (m_hs) begin
                  if (last_sym) begin
                     state    <= IDLE;
                     k        <= 3'd0;
                     tvalid_q <= 1'b0;
                     tlast_q  <= 1'b0;
                  end else begin
                     k       <= k + 3'd1;
                     tdata_q <= next_tdata;
                     tlast_q <= next_last;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign s_axis.tready = s_ready;
   assign m_axis.tdata  = tdata_q;
   assign m_axis.tvalid = tvalid_q;
   assign m_axis.tlast  = tlast_q;

endmodule

// File: tb/tb_qam_mapper_axis.sv
// -----------------------------------------------------------------------------
// tb_qam_mapper_axis
// Self-checking bench for qam_mapper_axis. A queue of expected symbols is
// filled from each accepted byte using the constellation rules directly and
// drained on each output handshake; every cycle the DUT's valid, ready,
// data and last are compared against it. Directed cases pin the model and
// the DUT to hand-computed constellation points.
// Honours QAM_MAPPER_CONJ_EN for the output layout.
// -----------------------------------------------------------------------------
module tb_qam_mapper_axis;

   localparam int IQ_W = 16;
   localparam int S16  = 4914;
   localparam int SQ   = 10988;
   localparam int SB   = 15539;
`ifdef QAM_MAPPER_CONJ_EN
   localparam int TDATA_W = 4 * IQ_W;
`else
   localparam int TDATA_W = 2 * IQ_W;
`endif

   typedef struct {
      int   i;
      int   q;
      logic last;
   } sym_t;

   logic       aclk = 1'b0;
   logic       areset;
   logic [1:0] mode;

   qam_mapper_axis_if #(.DATA_W(8))       s_if ();
   qam_mapper_axis_if #(.DATA_W(TDATA_W)) m_if ();

   qam_mapper_axis #(
      .IQ_W        (IQ_W),
      .SCALE_16QAM (S16),
      .SCALE_QPSK  (SQ),
      .SCALE_BPSK  (SB)
   ) dut (
      .aclk   (aclk),
      .areset (areset),
      .mode   (mode),
      .s_axis (s_if),
      .m_axis (m_if)
   );

   always #5 aclk = ~aclk;

   sym_t exp_q[$];
   int   n_checks   = 0;
   int   n_fail     = 0;
   bit   rand_ready = 1'b0;

   // 0xA5 read LSB-first is 1,0,1,0,0,1,0,1; a set bit gives the negative level.
   int   bpsk_a5[8] = '{-SB, SB, -SB, SB, SB, -SB, SB, -SB};

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   // Behavioural constellation: the symbol's bit field is cut out of the
   // byte arithmetically and mapped straight from the level tables.
   function automatic void model_sym(input logic [7:0] b, input logic [1:0] md, input int j,
                                     output int i, output int q);
      int lv[4] = '{1, 3, -1, -3};
      int bps;
      int bits;
      bps  = (md == 2'd0) ? 1 : (md == 2'd1) ? 2 : 4;
      bits = (int'(b) >> (j * bps)) & ((1 << bps) - 1);
      if (md == 2'd0) begin
         i = (bits != 0) ? -SB : SB;
         q = 0;
      end else if (md == 2'd1) begin
         q = ((bits & 1) != 0) ? -SQ : SQ;
         i = ((bits & 2) != 0) ? -SQ : SQ;
      end else begin
         i = lv[bits >> 2] * S16;
         q = lv[bits & 3] * S16;
      end
   endfunction

   function automatic int n_syms(input logic [1:0] md);
      return (md == 2'd0) ? 8 : (md == 2'd1) ? 4 : 2;
   endfunction

   function automatic logic [TDATA_W-1:0] pack(input int i, input int q);
`ifdef QAM_MAPPER_CONJ_EN
      return {IQ_W'(-q), IQ_W'(i), IQ_W'(q), IQ_W'(i)};
`else
      return {IQ_W'(q), IQ_W'(i)};
`endif
   endfunction

   // Per-cycle comparison against the expected-symbol queue.
   initial begin
      forever begin
         @(negedge aclk);
         if (areset) begin
            exp_q.delete();
            checkOutput("rst_tvalid", m_if.tvalid, 0);
            checkOutput("rst_tlast", m_if.tlast, 0);
            checkOutput("rst_tdata", m_if.tdata, 0);
         end else begin
            checkOutput("tvalid", m_if.tvalid, exp_q.size() != 0);
            checkOutput("s_tready", s_if.tready,
                        (exp_q.size() == 0) || (exp_q.size() == 1 && m_if.tready));
            if (m_if.tvalid && exp_q.size() != 0) begin
               checkOutput("tdata", m_if.tdata, pack(exp_q[0].i, exp_q[0].q));
               checkOutput("tlast", m_if.tlast, exp_q[0].last);
               if (m_if.tready) void'(exp_q.pop_front());
            end
            if (s_if.tvalid && s_if.tready) begin
               for (int j = 0; j < n_syms(mode); j++) begin
                  sym_t s;
                  model_sym(s_if.tdata, mode, j, s.i, s.q);
                  s.last = s_if.tlast && (j == n_syms(mode) - 1);
                  exp_q.push_back(s);
               end
            end
         end
      end
   end

   // Random backpressure on the output side.
   initial begin
      forever begin
         @(posedge aclk);
         #1;
         if (rand_ready) m_if.tready = 1'($urandom_range(0, 1));
      end
   end

   // Offers one byte and returns just after the edge that accepts it.
   task automatic applyStimulus(input logic [7:0] b, input logic [1:0] md, input logic lst);
      int   waited;
      logic hs;
      waited      = 0;
      s_if.tdata  = b;
      s_if.tlast  = lst;
      mode        = md;
      s_if.tvalid = 1'b1;
      forever begin
         @(negedge aclk);
         hs = s_if.tready;
         @(posedge aclk);
         #1;
         if (hs) break;
         waited++;
         if (waited > 100) begin
            checkOutput("accept_timeout", 0, 1);
            break;
         end
      end
   endtask

   // Captures the next output handshake; waited counts idle cycles before it.
   task automatic get_sym(output int i, output int q, output int cq, output logic l, output int waited);
      i = 0; q = 0; cq = 0; l = 1'b0; waited = 0;
      forever begin
         @(negedge aclk);
         if (m_if.tvalid && m_if.tready) begin
            i = int'($signed(m_if.tdata[IQ_W-1:0]));
            q = int'($signed(m_if.tdata[2*IQ_W-1:IQ_W]));
`ifdef QAM_MAPPER_CONJ_EN
            cq = int'($signed(m_if.tdata[4*IQ_W-1:3*IQ_W]));
`endif
            l = m_if.tlast;
            break;
         end
         waited++;
         if (waited > 50) begin
            checkOutput("sym_timeout", 0, 1);
            break;
         end
      end
      @(posedge aclk);
      #1;
   endtask

   initial begin
      int   i, q, cq, w;
      logic l;
      s_if.tvalid = 1'b0;
      s_if.tdata  = 8'd0;
      s_if.tlast  = 1'b0;
      mode        = 2'd0;
      m_if.tready = 1'b0;
      areset      = 1'b1;
      repeat (3) @(posedge aclk);
      #1;
      areset = 1'b0;
      @(negedge aclk);
      checkOutput("post_reset_s_tready", s_if.tready, 1);
      checkOutput("post_reset_tvalid", m_if.tvalid, 0);
      @(posedge aclk);
      #1;

      // Model pinned to hand-computed constellation points
      for (int j = 0; j < 8; j++) begin
         model_sym(8'hA5, 2'd0, j, i, q);
         checkOutput("model_bpsk_i", i, bpsk_a5[j]);
         checkOutput("model_bpsk_q", q, 0);
      end
      model_sym(8'h51, 2'd2, 0, i, q);
      checkOutput("model_qam_s0_i", i, 4914);
      checkOutput("model_qam_s0_q", q, 14742);
      model_sym(8'h51, 2'd3, 1, i, q);
      checkOutput("model_rsvd_s1_i", i, 14742);
      model_sym(8'h1B, 2'd1, 0, i, q);
      checkOutput("model_qpsk_s0_i", i, -10988);
      checkOutput("model_qpsk_s0_q", q, -10988);

      // 16-QAM byte 0x51
      m_if.tready = 1'b1;
      applyStimulus(8'h51, 2'd2, 1'b0);
      s_if.tvalid = 1'b0;
      get_sym(i, q, cq, l, w);
      checkOutput("qam51_latency", w, 0);
      checkOutput("qam51_s0_i", i, 4914);
      checkOutput("qam51_s0_q", q, 14742);
      checkOutput("qam51_s0_last", l, 0);
`ifdef QAM_MAPPER_CONJ_EN
      checkOutput("qam51_s0_conj_q", cq, -14742);
`endif
      get_sym(i, q, cq, l, w);
      checkOutput("qam51_s1_i", i, 14742);
      checkOutput("qam51_s1_q", q, 14742);
`ifdef QAM_MAPPER_CONJ_EN
      checkOutput("qam51_s1_conj_q", cq, -14742);
`endif

      // BPSK byte 0xA5 ending a frame
      applyStimulus(8'hA5, 2'd0, 1'b1);
      s_if.tvalid = 1'b0;
      for (int j = 0; j < 8; j++) begin
         get_sym(i, q, cq, l, w);
         checkOutput("bpsk_a5_i", i, bpsk_a5[j]);
         checkOutput("bpsk_a5_q", q, 0);
         checkOutput("bpsk_a5_last", l, j == 7);
      end

      // QPSK back-to-back 0x1B then 0xE4
      applyStimulus(8'h1B, 2'd1, 1'b0);
      applyStimulus(8'hE4, 2'd1, 1'b1);
      s_if.tvalid = 1'b0;
      for (int j = 0; j < 4; j++) begin
         int ei, eq;
         ei = (j >= 2) ? -SQ : SQ;
         eq = (j == 1 || j == 3) ? -SQ : SQ;
         get_sym(i, q, cq, l, w);
         checkOutput("qpsk_e4_gap", w, 0);
         checkOutput("qpsk_e4_i", i, ei);
         checkOutput("qpsk_e4_q", q, eq);
         checkOutput("qpsk_e4_last", l, j == 3);
      end

      // Random bytes, modes and gaps under random backpressure
      rand_ready = 1'b1;
      repeat (300) begin
         if ($urandom_range(0, 3) == 0) begin
            s_if.tvalid = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge aclk);
            #1;
         end
         applyStimulus(8'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end
      s_if.tvalid = 1'b0;
      rand_ready  = 1'b0;
      @(posedge aclk);
      #1;
      m_if.tready = 1'b1;
      w = 0;
      while (exp_q.size() != 0 && w < 100) begin
         @(posedge aclk);
         #1;
         w++;
      end
      checkOutput("drain", exp_q.size(), 0);

      // Reset while symbol 1 of a 16-QAM byte is on the output
      applyStimulus(8'hC7, 2'd2, 1'b0);
      s_if.tvalid = 1'b0;
      @(posedge aclk);
      #1;
      checkOutput("pre_reset_tvalid", m_if.tvalid, 1);
      areset = 1'b1;
      #1;
      checkOutput("async_reset_tvalid", m_if.tvalid, 0);
      @(posedge aclk);
      #1;
      areset = 1'b0;
      repeat (2) @(posedge aclk);
      #1;
      applyStimulus(8'h3E, 2'd2, 1'b1);
      s_if.tvalid = 1'b0;
      get_sym(i, q, cq, l, w);
      checkOutput("after_reset_s0_i", i, -14742);
      checkOutput("after_reset_s0_q", q, -4914);
      checkOutput("after_reset_s0_last", l, 0);
      get_sym(i, q, cq, l, w);
      checkOutput("after_reset_s1_i", i, 4914);
      checkOutput("after_reset_s1_q", q, -14742);
      checkOutput("after_reset_s1_last", l, 1);

      repeat (3) @(posedge aclk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
